// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone classic arbiter: three core-side masters share one slave port.
// A grant lasts for the owner's whole CYC tenure; a stall watchdog aborts hung transfers with ERR.
module wb_bus_arbiter #(
    parameter int ADDR_LEN       = 32,
    parameter int DATA_LEN       = 64,
    parameter int N_MASTERS      = 3,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_MASTERS-1:0]            m_cyc_i,
    input  logic [N_MASTERS-1:0]            m_stb_i,
    input  logic [N_MASTERS-1:0]            m_we_i,
    input  logic [N_MASTERS*ADDR_LEN-1:0]   m_adr_i,
    input  logic [N_MASTERS*DATA_LEN-1:0]   m_dat_i,
    input  logic [N_MASTERS*DATA_LEN/8-1:0] m_sel_i,
    output logic [N_MASTERS-1:0]            m_ack_o,
    output logic [N_MASTERS-1:0]            m_err_o,
    output logic [DATA_LEN-1:0]             m_dat_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [ADDR_LEN-1:0]             s_adr_o,
    output logic [DATA_LEN-1:0]             s_dat_o,
    output logic [DATA_LEN/8-1:0]           s_sel_o,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic [DATA_LEN-1:0]             s_dat_i,
    output logic [N_MASTERS-1:0]            grant_o,
    output logic                            timeout_o
);

    localparam int SEL_LEN = DATA_LEN / 8;
    localparam int IW      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [N_MASTERS-1:0]   r_grant;
    logic [IW-1:0]          r_last;
    logic [TO_W-1:0]        r_wd;
    logic                   r_timeout;

    logic                   w_cyc_g;
    logic                   w_stb_g;
    logic                   w_we_g;
    logic [ADDR_LEN-1:0]    w_adr_g;
    logic [DATA_LEN-1:0]    w_dat_g;
    logic [SEL_LEN-1:0]     w_sel_g;

    logic                   w_pick_found;
    logic [IW-1:0]          w_pick_idx;
    logic [N_MASTERS-1:0]   w_pick_oh;

    logic                   w_in_bus;
    logic                   w_in_abort;
    logic                   w_stall;
    logic                   w_wd_hit;

    // Owner's request signals, selected by the one-hot grant (all zero when nobody owns the bus).
    always_comb begin
        w_cyc_g = 1'b0;
        w_stb_g = 1'b0;
        w_we_g  = 1'b0;
        w_adr_g = '0;
        w_dat_g = '0;
        w_sel_g = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_cyc_g = m_cyc_i[i];
                w_stb_g = m_stb_i[i];
                w_we_g  = m_we_i[i];
                w_adr_g = m_adr_i[i*ADDR_LEN +: ADDR_LEN];
                w_dat_g = m_dat_i[i*DATA_LEN +: DATA_LEN];
                w_sel_g = m_sel_i[i*SEL_LEN +: SEL_LEN];
            end
        end
    end

    // Round-robin pick on CYC only: first requester after the last owner, wrapping.
    always_comb begin
        int v_idx;
        v_idx        = 0;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_pick_oh    = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            v_idx = (int'(r_last) + k) % N_MASTERS;
            if (!w_pick_found && m_cyc_i[IW'(v_idx)]) begin
                w_pick_found          = 1'b1;
                w_pick_idx            = IW'(v_idx);
                w_pick_oh[IW'(v_idx)] = 1'b1;
            end
        end
    end

    assign w_in_bus   = (r_state == ST_BUS);
    assign w_in_abort = (r_state == ST_ABORT);

    // A stalled cycle is an outstanding strobe that neither ACK nor ERR answers.
    assign w_stall  = w_in_bus & w_cyc_g & w_stb_g & ~s_ack_i & ~s_err_i;
    assign w_wd_hit = w_stall & (r_wd == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_last    <= IW'(N_MASTERS - 1);
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wd <= '0;
                    if (w_pick_found) begin
                        r_grant <= w_pick_oh;
                        r_last  <= w_pick_idx;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (!w_cyc_g) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_wd    <= '0;
                    end else if (w_wd_hit) begin
                        r_state   <= ST_ABORT;
                        r_timeout <= 1'b1;
                        r_wd      <= '0;
                    end else if (w_stall) begin
                        r_wd <= r_wd + 1'b1;
                    end else begin
                        r_wd <= '0;
                    end
                end
                ST_ABORT: begin
                    r_wd <= '0;
                    if (!w_cyc_g) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_wd    <= '0;
                end
            endcase
        end
    end

    // Wishbone handshake: a beat transfers in any cycle where CYC and STB are high and the slave
    // answers ACK (or ERR); ACK/ERR go back to the owner in that same cycle and only while it holds CYC.
    assign s_cyc_o = w_in_bus & w_cyc_g;
    assign s_stb_o = w_in_bus & w_cyc_g & w_stb_g;
    assign s_we_o  = w_in_bus & w_we_g;
    assign s_adr_o = w_in_bus ? w_adr_g : '0;
    assign s_dat_o = w_in_bus ? w_dat_g : '0;
    assign s_sel_o = w_in_bus ? w_sel_g : '0;

    assign m_ack_o = (w_in_bus && w_cyc_g && s_ack_i) ? r_grant : '0;
    assign m_err_o = ((w_in_bus && w_cyc_g && s_err_i) || (w_in_abort && r_timeout)) ? r_grant : '0;
    assign m_dat_o = s_dat_i;

    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: arbitration order, routing, watchdog abort, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int N  = 3;
    localparam int SW = DW / 8;

    logic              clk;
    logic              reset;
    logic [N-1:0]      m_cyc_i;
    logic [N-1:0]      m_stb_i;
    logic [N-1:0]      m_we_i;
    logic [N*AW-1:0]   m_adr_i;
    logic [N*DW-1:0]   m_dat_i;
    logic [N*SW-1:0]   m_sel_i;
    logic [N-1:0]      m_ack_o;
    logic [N-1:0]      m_err_o;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_ack_i;
    logic              s_err_i;
    logic [DW-1:0]     s_dat_i;
    logic [N-1:0]      grant_o;
    logic              timeout_o;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  exp_gnt_q[$];
    logic [DW-1:0] exp_dat_q[$];

    wb_bus_arbiter #(
        .ADDR_LEN      (AW),
        .DATA_LEN      (DW),
        .N_MASTERS     (N),
        .TIMEOUT_CYCLES(4),
        .TO_W          (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_sel_i  (m_sel_i),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_dat_o  (m_dat_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .s_dat_i  (s_dat_i),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit obs=expired exp=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m_cyc_i[i]          = cyc;
        m_stb_i[i]          = stb;
        m_we_i[i]           = we;
        m_adr_i[i*AW +: AW] = adr;
        m_dat_i[i*DW +: DW] = dat;
        m_sel_i[i*SW +: SW] = 8'hFF;
    endtask

    task automatic clear_inputs();
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Called during an IDLE cycle: expects exactly one dead cycle, then the grant at the queue head.
    task automatic wait_grant(input string tag);
        int idle;
        int k;
        bit got;
        logic [N-1:0] exp;
        idle = 0;
        k    = 0;
        got  = 1'b0;
        while (!got && k < 16) begin
            @(negedge clk);
            if (grant_o != '0) got = 1'b1;
            else idle++;
            k++;
        end
        if (!got) begin
            check({tag, "_bound"}, 64'd0, 64'd1);
        end else begin
            exp = exp_gnt_q.pop_front();
            check(tag, grant_o, exp);
            check({tag, "_idle"}, idle, 1);
        end
    endtask

    initial begin
        int cnt;
        int k;
        reset = 1'b1;
        clear_inputs();

        // reset state
        @(negedge clk);
        check("rst_grant", grant_o, 0);
        check("rst_cyc", s_cyc_o, 0);
        check("rst_stb", s_stb_o, 0);
        check("rst_adr", s_adr_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_ack", m_ack_o, 0);
        check("rst_err", m_err_o, 0);

        // m0 and m1 request together after reset release
        step();
        reset = 1'b0;
        set_m(0, 1, 0, 0, 32'h0000_1000, 64'h0);
        set_m(1, 1, 0, 0, 32'h0000_2000, 64'h0);
        exp_gnt_q.push_back(3'b001);
        exp_gnt_q.push_back(3'b010);
        wait_grant("t1_g0");
        check("t1_adr", s_adr_o, 32'h0000_1000);
        check("t1_cyc", s_cyc_o, 1);
        step();
        m_cyc_i[0] = 1'b0;
        step();
        wait_grant("t1_g1");
        check("t1_adr1", s_adr_o, 32'h0000_2000);
        step();
        m_cyc_i[1] = 1'b0;
        step();

        // round-robin fairness, one acked beat per tenure
        do_reset();
        for (int i = 0; i < N; i++) set_m(i, 1, 0, 0, AW'(32'h100 * (i + 1)), DW'(i));
        exp_gnt_q.push_back(3'b001);
        exp_gnt_q.push_back(3'b010);
        exp_gnt_q.push_back(3'b100);
        exp_gnt_q.push_back(3'b001);
        for (int r = 0; r < 4; r++) begin
            int owner;
            wait_grant($sformatf("rr%0d", r));
            owner = (grant_o == 3'b001) ? 0 : (grant_o == 3'b010) ? 1 : 2;
            step();
            m_stb_i[owner] = 1'b1;
            s_ack_i        = 1'b1;
            @(negedge clk);
            check($sformatf("rr%0d_ack", r), m_ack_o, 3'b1 << owner);
            step();
            m_stb_i[owner] = 1'b0;
            m_cyc_i[owner] = 1'b0;
            s_ack_i        = 1'b0;
            step();
            m_cyc_i[owner] = 1'b1;
        end
        step();

        // single-cycle read from m2
        do_reset();
        set_m(2, 1, 1, 0, 32'h8000_0010, 64'h0);
        exp_gnt_q.push_back(3'b100);
        exp_dat_q.push_back(64'hDEAD_BEEF_0123_4567);
        wait_grant("t3_g");
        s_dat_i = 64'hDEAD_BEEF_0123_4567;
        s_ack_i = 1'b1;
        #1;
        check("t3_adr", s_adr_o, 32'h8000_0010);
        check("t3_we", s_we_o, 0);
        check("t3_ack", m_ack_o, 3'b100);
        check("t3_ack_others", m_ack_o[1:0], 0);
        if (m_ack_o[2]) check("t3_dat", m_dat_o, exp_dat_q.pop_front());
        step();
        s_ack_i = 1'b0;
        set_m(2, 0, 0, 0, 32'h0, 64'h0);
        step();

        // watchdog: m1 strobes, slave never answers
        do_reset();
        set_m(1, 1, 1, 0, 32'h0000_3000, 64'h0);
        exp_gnt_q.push_back(3'b010);
        wait_grant("t4_g");
        cnt = 0;
        k   = 0;
        while (k < 16 && s_cyc_o && s_stb_o) begin
            cnt++;
            k++;
            @(negedge clk);
        end
        check("t4_stall_cycles", cnt, 4);
        check("t4_abort_cyc", s_cyc_o, 0);
        check("t4_abort_err", m_err_o, 3'b010);
        check("t4_abort_to", timeout_o, 1);
        @(negedge clk);
        check("t4_err_once", m_err_o, 0);
        check("t4_to_once", timeout_o, 0);
        check("t4_hold_cyc", s_cyc_o, 0);
        check("t4_hold_grant", grant_o, 3'b010);
        step();
        m_cyc_i[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_idle", grant_o, 0);

        // slave ERR on an m0 write, then an ACK after CYC is gone
        do_reset();
        set_m(0, 1, 1, 1, 32'h0000_4000, 64'h1122_3344_5566_7788);
        exp_gnt_q.push_back(3'b001);
        wait_grant("t5_g");
        check("t5_we", s_we_o, 1);
        check("t5_wdat", s_dat_o, 64'h1122_3344_5566_7788);
        check("t5_sel", s_sel_o, 8'hFF);
        s_err_i = 1'b1;
        #1;
        check("t5_err", m_err_o, 3'b001);
        check("t5_noack", m_ack_o, 0);
        step();
        s_err_i    = 1'b0;
        m_stb_i[0] = 1'b0;
        @(negedge clk);
        check("t5_keep_grant", grant_o, 3'b001);
        step();
        m_cyc_i[0] = 1'b0;
        step();
        s_ack_i = 1'b1;
        #1;
        check("t5_late_ack", m_ack_o, 0);
        check("t5_late_grant", grant_o, 0);
        step();
        s_ack_i = 1'b0;

        // async reset in the middle of an m1 burst
        do_reset();
        set_m(1, 1, 1, 0, 32'h0000_5000, 64'h0);
        exp_gnt_q.push_back(3'b010);
        wait_grant("t6_g");
        s_ack_i = 1'b1;
        #1;
        check("t6_beat0", m_ack_o, 3'b010);
        step();
        @(negedge clk);
        check("t6_beat1", m_ack_o, 3'b010);
        m_cyc_i[0] = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_cyc", s_cyc_o, 0);
        check("t6_rst_stb", s_stb_o, 0);
        check("t6_rst_grant", grant_o, 0);
        check("t6_rst_ack", m_ack_o, 0);
        s_ack_i = 1'b0;
        step();
        reset = 1'b0;
        exp_gnt_q.push_back(3'b001);
        wait_grant("t6_prio");

        // final report
        check("gnt_q_empty", exp_gnt_q.size(), 0);
        check("dat_q_empty", exp_dat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Round-robin Wishbone classic arbiter that shares one external Wishbone slave port between three core-side masters: icache refill (m0), dcache refill (m1) and the uncached "others" path (m2).
- Sits between the core top level and the SoC bus.
- Holds a grant for the full CYC tenure of the winning master.
- Aborts hung transfers with a watchdog that returns ERR to the master.

Parameters:
- ADDR_LEN, 32, Wishbone address width.
- DATA_LEN, 64, Wishbone data width; must be a multiple of 8.
- N_MASTERS, 3, number of requesters; the RR logic is generic, and the bench covers 3.
- TIMEOUT_CYCLES, 255, number of stalled cycles before the watchdog aborts; must be ≥2 and fit in TO_W bits.
- TO_W, 8, watchdog counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- m_cyc_i  in  N_MASTERS  per-master CYC.
- m_stb_i  in  N_MASTERS  per-master STB.
- m_we_i  in  N_MASTERS  per-master WE.
- m_adr_i  in  N_MASTERS*ADDR_LEN  flattened addresses; master i occupies slice i.
- m_dat_i  in  N_MASTERS*DATA_LEN  flattened write data.
- m_sel_i  in  N_MASTERS*DATA_LEN/8  flattened byte selects.
- m_ack_o  out  N_MASTERS  ACK, routed to the granted master only.
- m_err_o  out  N_MASTERS  ERR, routed to the granted master only.
- m_dat_o  out  DATA_LEN  read data, broadcast to all masters (s_dat_i).
- s_cyc_o  out  1  slave CYC.
- s_stb_o  out  1  slave STB.
- s_we_o  out  1  slave WE.
- s_adr_o  out  ADDR_LEN  slave address.
- s_dat_o  out  DATA_LEN  slave write data.
- s_sel_o  out  DATA_LEN/8  slave byte selects.
- s_ack_i  in  1  slave ACK.
- s_err_i  in  1  slave ERR.
- s_dat_i  in  DATA_LEN  slave read data.
- grant_o  out  N_MASTERS  one-hot current owner; all zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async): state=IDLE, grant=0, last-owner pointer=N_MASTERS-1 so m0 has top priority first, watchdog=0, timeout_o=0. All s_* outputs and m_ack_o/m_err_o go to 0 immediately on reset assertion, including mid-transfer.
- States: IDLE, BUS, ABORT.

IDLE:
- s_cyc_o=s_stb_o=0 and the slave address/data outputs are 0.
- If any m_cyc_i is set, pick the first set bit scanning from (last_owner+1) mod N upward with wrap.
- Register grant and last_owner at the next edge and go to BUS.
- Arbitration uses CYC only; STB is ignored.

BUS:
- s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g], and we/adr/dat/sel are muxed combinationally from master g.
- m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i, combinational and same cycle. Non-granted masters see 0.
- Latency: a request sampled in IDLE at edge N appears on s_cyc_o in the cycle after edge N, so there is one idle cycle of arbitration.
- The master may issue any number of STB transfers while it holds CYC.
- When m_cyc_i[g]=0 at an edge, go to IDLE and clear grant. A new grant needs a further IDLE cycle, so there are no back-to-back grants without a dead cycle.
- A slave ACK arriving after CYC has dropped is ignored.

Watchdog:
- In BUS, the counter increments each cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
- It clears on ACK, on ERR, on STB=0, and on leaving BUS.
- When the counter equals TIMEOUT_CYCLES-1 while still stalled, go to ABORT at the next edge.
- In the first ABORT cycle: s_cyc_o=s_stb_o=0, m_err_o[g]=1 for exactly one cycle, and timeout_o=1 for the same cycle. Slave ack/err are ignored.
- Remain in ABORT with s_cyc_o=0 until m_cyc_i[g]=0, then go to IDLE.
- If the master drops CYC in the first ABORT cycle, go to IDLE at that edge.

Other rules:
- Width: the counter saturates at TIMEOUT_CYCLES-1 and never wraps.
- Simultaneous events:
  - ACK in the same cycle as the count reaching threshold: ACK wins and the counter clears.
  - s_ack_i and s_err_i both high: both are passed through unchanged.
- A master deasserting CYC without a completed transfer is legal; the arbiter releases silently.

Test Plan:
- Reset release, m0 and m1 both raise CYC at the same edge:
  - grant_o=3'b001 one cycle later and s_adr_o=m0 address.
  - m0 drops CYC: one idle cycle, then grant_o=3'b010.
- Round-robin fairness, all three masters hold CYC and each releases after one ACK:
  - grant sequence 001,010,100,001 with exactly one idle cycle between grants.
- Single-cycle ACK read from m2 (adr=0x8000_0010, slave returns s_dat_i=64'hDEAD_BEEF_0123_4567 with ACK in the first STB cycle):
  - m_ack_o=3'b100 in that same cycle and m_dat_o matches.
  - m_ack_o[0] and m_ack_o[1] stay 0.
- Watchdog, TIMEOUT_CYCLES=4, m1 holds STB and the slave never acks:
  - exactly 4 stalled cycles, then s_cyc_o=0, m_err_o=3'b010 and timeout_o=1 for 1 cycle.
  - m1 drops CYC: return to IDLE.
- Slave ERR, and late ACK:
  - s_err_i during an m0 write: m_err_o[0] is set the same cycle and the grant is kept until CYC drops.
  - an ACK injected after CYC drops reaches no master.
- Async reset asserted mid-burst of m1:
  - s_cyc_o and grant_o are 0 before the next clock edge.
  - after release, m0 has priority over a pending m1.
